// File: rtl/temp_avg_divider.sv
// Sequential restoring divider: temperature sum / active-sensor count -> average temperature.
// One quotient bit per clock; results are registered and announced with a one-cycle done_o pulse.
module temp_avg_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quotient_o,
    output logic [DIVISOR_W-1:0]  remainder_o,
    output logic                  div_by_zero_o
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [DIVIDEND_W-1:0] r_dividend;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W:0]    r_partial;
    logic [CNT_W-1:0]      r_count;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_by_zero;

    logic [DIVISOR_W:0]    w_trial;
    logic                  w_ge;
    logic [DIVISOR_W:0]    w_next_partial;
    logic [DIVIDEND_W-1:0] w_next_quot;

    // The dividend register doubles as the quotient register: quotient bits shift in at the LSB.
    assign w_trial        = {r_partial[DIVISOR_W-1:0], r_dividend[DIVIDEND_W-1]};
    assign w_ge           = r_partial[DIVISOR_W] | (w_trial >= {1'b0, r_divisor});
    assign w_next_partial = w_ge ? (w_trial - {1'b0, r_divisor}) : w_trial;
    assign w_next_quot    = {r_dividend[DIVIDEND_W-2:0], w_ge};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_partial     <= '0;
            r_count       <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_dividend <= dividend_i;
                        r_divisor  <= divisor_i;
                        r_partial  <= '0;
                        if (divisor_i != '0) begin
                            r_state <= S_BUSY;
                            r_count <= CNT_W'(DIVIDEND_W);
                        end else begin
                            r_state       <= S_DONE;
                            r_quotient    <= '0;
                            r_remainder   <= '0;
                            r_div_by_zero <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_partial  <= w_next_partial;
                    r_dividend <= w_next_quot;
                    r_count    <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state       <= S_DONE;
                        r_quotient    <= w_next_quot;
                        r_remainder   <= w_next_partial[DIVISOR_W-1:0];
                        r_div_by_zero <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o       = (r_state == S_IDLE);
    assign done_o        = (r_state == S_DONE);
    assign quotient_o    = r_quotient;
    assign remainder_o   = r_remainder;
    assign div_by_zero_o = r_div_by_zero;

endmodule
